dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed data memory (synchronous 1-cycle read, read data cleared when read strobe low).
- Shares the memory between port 0 (core load/store unit) and port 1 (debug/DMA).
- Sequences each access through a fixed 3-cycle grant/strobe/response schedule.
- Performs range and alignment checking, returning an error response instead of touching memory.

Parameters:
- MEM_BYTES, 4096, memory size in bytes; valid byte addresses 0..MEM_BYTES-1.
- ALIGN_CHECK, 1, when 1 a word access with addr[1:0]!=0 is faulted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pN_req  in  1  request from port N (N=0,1); held with fields stable until pN_ack.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  write data; byte writes use [7:0].
- pN_we  in  1  1=write, 0=read.
- pN_byte  in  1  1=byte access, 0=word access.
- pN_ack  out  1  one-cycle pulse: request accepted and fields latched.
- pN_done  out  1  one-cycle pulse: access complete.
- pN_rdata  out  32  read result; valid while pN_done=1, else 0.
- pN_err  out  1  qualifies pN_done; 1=faulted access.
- mem_address  out  32  to memory address.
- mem_write_data  out  32  to memory write_data.
- mem_write_enable  out  1  to memory write_enable.
- mem_read_enable  out  1  to memory read_enable.
- mem_byte_enable  out  1  to memory byte_enable.
- mem_read_data  in  32  from memory read_data.
- busy  out  1  high in ISSUE and RESP.
- grant  out  1  port owning the current or most recent transaction.

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1, so port 0 wins first contention; latched transaction cleared.
- States: IDLE -> ISSUE -> RESP -> IDLE, unconditional after leaving IDLE.
- IDLE:
  - If no req, stay.
  - If exactly one req, grant it.
  - If both req, grant port != last_grant (round-robin).
  - On grant: pulse pN_ack that cycle, latch addr/wdata/we/byte, set grant and last_grant, compute fault, go ISSUE.
- Fault rule:
  - Byte access faults if addr >= MEM_BYTES.
  - Word access faults if addr > MEM_BYTES-4, or if ALIGN_CHECK=1 and addr[1:0]!=0.
  - Compare full 32 bits; no wrap-around is permitted.
- ISSUE (1 cycle):
  - mem_address/mem_write_data/mem_byte_enable driven from latched values.
  - mem_write_enable=we&!fault; mem_read_enable=!we&!fault.
  - Mem strobes are combinationally decoded from state; high only in ISSUE.
  - Go RESP.
- RESP (1 cycle):
  - Pulse pN_done for the granted port.
  - pN_err=fault.
  - pN_rdata = mem_read_data for non-faulted reads, including the zero-extended byte result; 0 for writes and faults.
  - Go IDLE.
- Latency: ack cycle T, mem strobe T+1, done T+2. The next ack is no earlier than T+3, so peak throughput is 1 access per 3 cycles.
- No ack is given outside IDLE. Requests asserted while busy wait and are arbitrated on return to IDLE.
- A requester may keep req high after ack to queue its next access; that is then a new request.
- mem_address etc. hold the latched values outside ISSUE; strobes are 0.
- Non-granted port outputs stay 0.
- rst mid-transaction: in-flight access abandoned immediately, no done; mem strobes drop asynchronously.
- The memory is not guaranteed unwritten if rst asserts coincident with an ISSUE clock edge.

Test Plan:
- Port 0 write word 0xDEADBEEF to 0x10, then read 0x10 -> p0_ack at T, mem_write_enable at T+1 only, p0_done at T+2 err=0; read returns p0_rdata=0xDEADBEEF at its done cycle.
- Port 1 byte write 0xA5 to 0x13, then byte read 0x13 -> p1_rdata=0x000000A5; a word read of 0x10 returns 0xA5ADBEEF.
- Both ports request continuously from reset -> acks alternate 0,1,0,1 spaced 3 cycles; grant toggles; no port acked twice in a row.
- Word read at 0xFFD (MEM_BYTES=4096), word read at 0x11 (ALIGN_CHECK=1), byte write at 0x1000 -> no mem strobe in ISSUE, done with err=1 and rdata=0; prior contents of 0xFFC unchanged.
- Assert rst in the ISSUE cycle of a port 0 read -> all outputs 0 immediately, no p0_done; after release, port 0 wins simultaneous requests.
- Single requester holding req high for 4 reads -> acks at T, T+3, T+6, T+9; busy low only on ack cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin two-port arbiter sequencing data-memory accesses
//            through a fixed ack / strobe / response schedule with fault check.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_BYTES   = 4096,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_we,
  input  logic        p0_byte,
  output logic        p0_ack,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_we,
  input  logic        p1_byte,
  output logic        p1_ack,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic        mem_byte_enable,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        grant
);

  localparam logic [31:0] c_byte_limit = 32'(MEM_BYTES);
  localparam logic [31:0] c_word_limit = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_grant;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_byte;
  logic        r_fault;

  logic        w_accept;
  logic        w_sel;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_we;
  logic        w_sel_byte;
  logic        w_fault;
  logic [31:0] w_rdata;

  // Contention goes to the port that did not win last time.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && (p0_req || p1_req);
    w_sel       = (p0_req && p1_req) ? ~r_last_grant : p1_req;
    w_sel_addr  = w_sel ? p1_addr  : p0_addr;
    w_sel_wdata = w_sel ? p1_wdata : p0_wdata;
    w_sel_we    = w_sel ? p1_we    : p0_we;
    w_sel_byte  = w_sel ? p1_byte  : p0_byte;
  end

  // Full 32-bit compares so an address near 2^32 cannot wrap into range.
  always_comb begin
    if (w_sel_byte) begin
      w_fault = (w_sel_addr >= c_byte_limit);
    end else begin
      w_fault = (w_sel_addr > c_word_limit) ||
                ((ALIGN_CHECK != 1'b0) && (w_sel_addr[1:0] != 2'b00));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_we         <= 1'b0;
      r_byte       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_we         <= w_sel_we;
        r_byte       <= w_sel_byte;
        r_fault      <= w_fault;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    p0_ack           = w_accept && !w_sel;
    p1_ack           = w_accept &&  w_sel;
    p0_done          = (r_state == S_RESP) && !r_grant;
    p1_done          = (r_state == S_RESP) &&  r_grant;
    busy             = (r_state == S_ISSUE) || (r_state == S_RESP);
    grant            = r_grant;
    mem_address      = r_addr;
    mem_write_data   = r_wdata;
    mem_byte_enable  = r_byte;
    mem_write_enable = (r_state == S_ISSUE) &&  r_we && !r_fault;
    mem_read_enable  = (r_state == S_ISSUE) && !r_we && !r_fault;
    w_rdata          = 32'd0;
    if ((r_state == S_RESP) && !r_we && !r_fault) begin
      w_rdata = r_byte ? {24'd0, mem_read_data[7:0]} : mem_read_data;
    end
    p0_rdata = p0_done ? w_rdata : 32'd0;
    p1_rdata = p1_done ? w_rdata : 32'd0;
    p0_err   = p0_done && r_fault;
    p1_err   = p1_done && r_fault;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboard bench for dmem_arbiter with a byte-addressed memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p0_byte = 1'b0;
  logic [31:0] p0_addr = 32'd0, p0_wdata = 32'd0;
  logic        p1_req = 1'b0, p1_we = 1'b0, p1_byte = 1'b0;
  logic [31:0] p1_addr = 32'd0, p1_wdata = 32'd0;
  logic        p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_address, mem_write_data;
  logic        mem_write_enable, mem_read_enable, mem_byte_enable;
  logic [31:0] mem_read_data = 32'd0;
  logic        busy, grant;

  dmem_arbiter #(.MEM_BYTES(4096), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
    .p0_byte(p0_byte), .p0_ack(p0_ack), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_byte(p1_byte), .p1_ack(p1_ack), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_byte_enable(mem_byte_enable), .mem_read_data(mem_read_data),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Little-endian byte memory; read data is zero whenever the read strobe is low.
  logic [7:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

  function automatic logic [11:0] ix(input logic [31:0] a, input int off);
    logic [31:0] s;
    s = a + 32'(off);
    return s[11:0];
  endfunction

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[ix(mem_address, 0)] <= mem_write_data[7:0];
      if (!mem_byte_enable) begin
        mem[ix(mem_address, 1)] <= mem_write_data[15:8];
        mem[ix(mem_address, 2)] <= mem_write_data[23:16];
        mem[ix(mem_address, 3)] <= mem_write_data[31:24];
      end
    end
    if (mem_read_enable) begin
      if (mem_byte_enable) mem_read_data <= {24'd0, mem[ix(mem_address, 0)]};
      else mem_read_data <= {mem[ix(mem_address, 3)], mem[ix(mem_address, 2)],
                             mem[ix(mem_address, 1)], mem[ix(mem_address, 0)]};
    end else begin
      mem_read_data <= 32'd0;
    end
  end

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_port_log[$];
  int   ack_cyc_log[$];
  int   ack_cyc = 0;
  bit   ack_port = 1'b0;
  bit   have_ack = 1'b0;

  function automatic void check32(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endfunction

  wire [138:0] all_out = {p0_ack, p0_done, p0_rdata, p0_err, p1_ack, p1_done,
                          p1_rdata, p1_err, mem_address, mem_write_data,
                          mem_write_enable, mem_read_enable, mem_byte_enable,
                          busy, grant};

  // Monitor: timing of ack/strobe/done and scoreboard pops on every done.
  exp_t m_e;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (p0_ack || p1_ack) begin
        check1("ack_exclusive", p0_ack && p1_ack, 1'b0);
        check1("ack_busy", busy, 1'b0);
        if (have_ack) check1("ack_spacing", (cyc - ack_cyc) >= 3, 1'b1);
        ack_cyc  = cyc;
        ack_port = p1_ack;
        have_ack = 1'b1;
        ack_port_log.push_back(int'(p1_ack));
        ack_cyc_log.push_back(cyc);
      end
      if (have_ack && cyc == ack_cyc + 1) begin
        if ((ack_port ? q1.size() : q0.size()) == 0) begin
          check1("issue_has_expect", 1'b0, 1'b1);
        end else begin
          m_e = ack_port ? q1[0] : q0[0];
          check32("issue_addr", mem_address, m_e.addr);
          check1("issue_we", mem_write_enable, m_e.we && !m_e.err);
          check1("issue_re", mem_read_enable, !m_e.we && !m_e.err);
          check1("issue_grant", grant, ack_port);
          check1("issue_busy", busy, 1'b1);
        end
      end else begin
        check1("strobe_idle", mem_write_enable || mem_read_enable, 1'b0);
      end
      if (p0_done || p1_done) begin
        check1("done_exclusive", p0_done && p1_done, 1'b0);
        check1("done_port", p1_done, ack_port);
        check1("done_latency", cyc == ack_cyc + 2, 1'b1);
        check1("done_busy", busy, 1'b1);
        if ((p1_done ? q1.size() : q0.size()) == 0) begin
          check1("unexpected_done", 1'b1, 1'b0);
        end else begin
          m_e = p1_done ? q1.pop_front() : q0.pop_front();
          check32("done_rdata", p1_done ? p1_rdata : p0_rdata, m_e.rdata);
          check1("done_err", p1_done ? p1_err : p0_err, m_e.err);
          check32("idle_port_rdata", p1_done ? p0_rdata : p1_rdata, 32'd0);
        end
      end else begin
        check32("rdata_idle", p0_rdata | p1_rdata, 32'd0);
        check1("err_idle", p0_err || p1_err, 1'b0);
      end
    end
  end

  task automatic access(input bit p, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit we, input bit bt, input logic [31:0] exp_rdata,
                        input bit exp_err);
    int n;
    exp_t e;
    e = '{addr: addr, we: we, rdata: exp_rdata, err: exp_err};
    if (p) begin
      q1.push_back(e);
      p1_addr = addr; p1_wdata = wdata; p1_we = we; p1_byte = bt; p1_req = 1'b1;
    end else begin
      q0.push_back(e);
      p0_addr = addr; p0_wdata = wdata; p0_we = we; p0_byte = bt; p0_req = 1'b1;
    end
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (p ? p1_ack : p0_ack) break;
    end
    check1("ack_timeout", n < 20, 1'b1);
    @(posedge clk); #1;
    if (p) p1_req = 1'b0; else p0_req = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (p ? p1_done : p0_done) break;
    end
    check1("done_timeout", n < 20, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, c1;
    repeat (3) @(negedge clk);
    check1("reset_outputs", |all_out, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check1("post_reset_outputs", |all_out, 1'b0);
    @(posedge clk); #1;

    // Word write then read back.
    access(1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0, 1'b0);
    access(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    // Byte write lands in the top byte of the little-endian word.
    access(1'b1, 32'h13, 32'hFFFFFFA5, 1'b1, 1'b1, 32'd0, 1'b0);
    access(1'b1, 32'h13, 32'd0, 1'b0, 1'b1, 32'h000000A5, 1'b0);
    access(1'b1, 32'h10, 32'd0, 1'b0, 1'b0, 32'hA5ADBEEF, 1'b0);

    // Faulted accesses must not touch memory.
    access(1'b0, 32'hFFC, 32'h11223344, 1'b1, 1'b0, 32'd0, 1'b0);
    access(1'b0, 32'hFFD, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    access(1'b1, 32'h11, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    access(1'b0, 32'h1000, 32'h000000EE, 1'b1, 1'b1, 32'd0, 1'b1);
    access(1'b1, 32'hFFFFFFFC, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    access(1'b0, 32'hFFF, 32'd0, 1'b0, 1'b1, 32'h00000011, 1'b0);
    access(1'b0, 32'hFFC, 32'd0, 1'b0, 1'b0, 32'h11223344, 1'b0);
    access(1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'h00000000, 1'b0);

    // Reset during the ISSUE cycle of a read abandons it.
    p0_addr = 32'h10; p0_we = 1'b0; p0_byte = 1'b0; p0_req = 1'b1;
    @(negedge clk);
    check1("rst_test_ack", p0_ack, 1'b1);
    @(posedge clk); #1 p0_req = 1'b0;
    check1("rst_test_strobe", mem_read_enable, 1'b1);
    #1 rst = 1'b1;
    #1 check1("rst_async_outputs", |all_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Continuous contention straight out of reset: port 0 first, then alternate.
    ack_port_log.delete();
    ack_cyc_log.delete();
    c0 = 0; c1 = 0;
    p0_addr = 32'h10; p0_we = 1'b0; p0_byte = 1'b0;
    p1_addr = 32'h13; p1_we = 1'b0; p1_byte = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{addr: 32'h10, we: 1'b0, rdata: 32'hA5ADBEEF, err: 1'b0});
      q1.push_back('{addr: 32'h13, we: 1'b0, rdata: 32'h000000A5, err: 1'b0});
    end
    p0_req = 1'b1; p1_req = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (p0_ack) c0++;
      if (p1_ack) c1++;
      @(posedge clk); #1;
      if (c0 >= 3) p0_req = 1'b0;
      if (c1 >= 3) p1_req = 1'b0;
      if (c0 >= 3 && c1 >= 3) break;
    end
    check1("contention_counts", c0 == 3 && c1 == 3, 1'b1);
    check1("contention_log_len", ack_port_log.size() == 6, 1'b1);
    for (int i = 0; i < ack_port_log.size(); i++) begin
      check32("contention_order", 32'(ack_port_log[i]), 32'(i % 2));
      if (i > 0) check32("contention_gap", 32'(ack_cyc_log[i] - ack_cyc_log[i-1]), 32'd3);
    end
    repeat (3) @(posedge clk);
    #1;

    // Single requester holding req for four back-to-back reads.
    p0_addr = 32'hFFC; p0_we = 1'b0; p0_byte = 1'b0;
    for (int i = 0; i < 4; i++)
      q0.push_back('{addr: 32'hFFC, we: 1'b0, rdata: 32'h11223344, err: 1'b0});
    p0_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check1("hold_ack", p0_ack, (k % 3) == 0);
      check1("hold_busy", busy, (k % 3) != 0);
      @(posedge clk); #1;
      if (k == 9) p0_req = 1'b0;
    end
    @(negedge clk);
    check1("hold_no_extra_ack", p0_ack, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    check32("q0_drained", 32'(q0.size()), 32'd0);
    check32("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
